run_monitor: RTL and testbench
==============================

# run_monitor

Synthesizable run-control and post-mortem dump unit for the 8-bit machine. It replaces the bench-only halt/timeout handling with reusable hardware. It gates a run, counts cycles, and detects CPU halt or a watchdog timeout. It then snapshots the register file and streams registers plus a configurable RAM window out over a valid/ready port. It sits beside `machine`, taps `m_cpu` halt and register state, and borrows a read port on `m_ram`.

## Interface
Parameters:
- DATA_W, 8, register and RAM word width
- ADDR_W, 8, RAM address width
- NUM_REGS, 8, number of registers snapshotted (A..G, Temp order), >=1
- TIMEOUT_CYCLES, 140, watchdog limit in RUN cycles; 0 disables the watchdog
- DUMP_BASE, 0, first RAM address dumped
- DUMP_LEN, 1, number of RAM words dumped; 0 skips the memory phase

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high; all state returns to IDLE on the next clk edge
- start  in  1  begin a run (sampled in IDLE and DONE)
- halted  in  1  CPU halted level
- regs_flat  in  NUM_REGS*DATA_W  register file; reg i occupies bits [i*DATA_W +: DATA_W]
- mem_rd  out  1  RAM read strobe
- mem_addr  out  ADDR_W  RAM read address
- mem_data  in  DATA_W  RAM read data, valid the cycle after mem_rd
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  sink accepts the beat
- dump_data  out  DATA_W  beat payload
- dump_is_mem  out  1  0 = register beat, 1 = memory beat
- dump_index  out  ADDR_W  register number or RAM address
- dump_last  out  1  final beat of the dump
- running  out  1  high in RUN (machine clock-enable)
- done  out  1  high in DONE
- timed_out  out  1  run ended by the watchdog, held until the next start or reset
- cycle_count  out  32  RUN cycles elapsed, frozen after RUN

## Operation
- States: IDLE, RUN, SNAP, DUMP_REG, MEM_RD, MEM_WAIT, DUMP_MEM, DONE.
- IDLE/DONE with start=1 → RUN. On the same edge, cycle_count and timed_out are cleared.
- RUN, per cycle:
  - If halted=1: → SNAP; the count is not incremented.
  - Else: the count increments. If TIMEOUT_CYCLES≠0 and the new count equals TIMEOUT_CYCLES: → SNAP and timed_out←1.
  - Halt and timeout in the same cycle: halt wins, timed_out stays 0.
- SNAP: latches regs_flat into an internal snapshot (one cycle) → DUMP_REG, reg index 0.
- DUMP_REG: presents snapshot[i].
  - On handshake, i increments.
  - After i=NUM_REGS-1: → MEM_RD if DUMP_LEN>0, else → DONE.
- MEM_RD: mem_rd=1 for exactly one cycle, mem_addr=(DUMP_BASE+j) mod 2^ADDR_W → MEM_WAIT.
- MEM_WAIT: captures mem_data → DUMP_MEM.
- DUMP_MEM: presents the captured word, index = address.
  - On handshake: j+1 < DUMP_LEN → MEM_RD, else → DONE.
- dump_last=1 only on the final beat: last memory beat, or last register beat when DUMP_LEN=0.
- Handshake: a beat transfers when dump_valid && dump_ready. While valid && !ready, data, index, is_mem and last are held stable. valid never drops without a transfer, except on reset.
- The snapshot is taken once; register changes after SNAP do not affect the dump.
- cycle_count saturates at 2^32-1.

## Timing
- Reset values:
  - state IDLE
  - all outputs 0, including mem_addr, dump_data, dump_index and cycle_count
- running is registered: it is high from the cycle after start is sampled until the cycle SNAP is entered.
- Halt-to-first-beat latency: 2 cycles (RUN→SNAP→DUMP_REG, valid in DUMP_REG).
- Each register beat takes at least 1 cycle; each memory beat takes at least 3 cycles (MEM_RD, MEM_WAIT, DUMP_MEM).
- Reset mid-dump: the next edge gives IDLE, valid=0, mem_rd=0, timed_out=0. No partial beat completes.
- start outside IDLE/DONE is ignored.

## Structure
- A shared package `monitor_pkg` holds the state enum `mon_state_t` and the beat-kind constants (KIND_REG=0, KIND_MEM=1).
- The only natural sub-module is `dump_stage`, a single-entry valid/ready output register holding payload, index, kind and last.
- Everything else lives in `run_monitor`.

## Test plan
- Halt path: regs 01..08, mem[00]=2A, halted rises after 10 RUN cycles, ready=1.
  - 9 beats: regs 0..7 = 01..08, then mem beat index 00 data 2A with last=1.
  - cycle_count=10, timed_out=0, done=1.
- Watchdog: TIMEOUT_CYCLES=4, halted held at 0.
  - SNAP entered after 4 RUN cycles.
  - cycle_count=4, timed_out=1, full dump follows.
- Simultaneous: TIMEOUT_CYCLES=4, halted=1 on the 4th RUN cycle → timed_out=0, cycle_count=3.
- Backpressure: dump_ready toggles 1/0 each cycle → every beat is stable while stalled, there are no duplicates or drops, and the beat order matches the halt path.
- Wrap: DUMP_BASE=FE, DUMP_LEN=4 → mem_rd addresses FE, FF, 00, 01 in order; last=1 on 01.
- Reset mid-dump: reset during the 3rd register beat.
  - Next cycle: IDLE, valid=0, done=0.
  - A new start then produces a complete dump from reg 0.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared types and constants for the run monitor: FSM state encoding,
// dump beat kinds and the cycle counter helper.
package monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_SNAP     = 3'd2,
        ST_DUMP_REG = 3'd3,
        ST_MEM_RD   = 3'd4,
        ST_MEM_WAIT = 3'd5,
        ST_DUMP_MEM = 3'd6,
        ST_DONE     = 3'd7
    } mon_state_t;

    // Beat kind carried on dump_is_mem.
    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    localparam int unsigned CYCLE_W = 32;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/run_monitor_dump_stage.sv
// Single-entry valid/ready output register for dump beats. A beat is
// loaded only when the stage is empty or draining in the same cycle, and
// is held unchanged while the sink stalls.
module dump_stage
    import monitor_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_index,
    input  logic              in_kind,
    input  logic              in_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] index,
    output logic              kind,
    output logic              last,
    output logic              fire
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              kind_q, kind_d;
    logic              last_q, last_d;

    assign fire  = valid_q && ready;
    assign valid = valid_q;
    assign data  = data_q;
    assign index = index_q;
    assign kind  = kind_q;
    assign last  = last_q;

    // Next beat: a load wins, otherwise a transfer empties the stage.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        valid_d = valid_q;
        data_d  = data_q;
        index_d = index_q;
        kind_d  = kind_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            index_d = in_index;
            kind_d  = in_kind;
            last_d  = in_last;
        end else if (fire) begin
            valid_d = 1'b0;
        end
    end

    // Beat register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            kind_q  <= KIND_REG;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            index_q <= index_d;
            kind_q  <= kind_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Run-control and post-mortem dump unit. Gates a run, counts RUN cycles,
// stops on CPU halt or watchdog expiry, snapshots the register file and
// streams registers followed by a RAM window over a valid/ready port.
module run_monitor
    import monitor_pkg::*;
#(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned NUM_REGS       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 140,
    parameter int unsigned DUMP_BASE      = 0,
    parameter int unsigned DUMP_LEN       = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         halted,
    input  logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         mem_rd,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [DATA_W-1:0]            mem_data,
    output logic                         dump_valid,
    input  logic                         dump_ready,
    output logic [DATA_W-1:0]            dump_data,
    output logic                         dump_is_mem,
    output logic [ADDR_W-1:0]            dump_index,
    output logic                         dump_last,
    output logic                         running,
    output logic                         done,
    output logic                         timed_out,
    output logic [31:0]                  cycle_count
);

    localparam int unsigned REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [REG_IDX_W-1:0] LAST_REG  = REG_IDX_W'(NUM_REGS - 1);
    localparam logic [31:0]          TIMEOUT_L = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0]          LEN_L     = 32'(DUMP_LEN);
    localparam logic [ADDR_W-1:0]    BASE_L    = ADDR_W'(DUMP_BASE);

    mon_state_t                  state_q, state_d;
    logic [31:0]                 cycle_count_q, cycle_count_d;
    logic                        timed_out_q, timed_out_d;
    logic                        running_q, running_d;
    logic                        done_q, done_d;
    logic                        mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
    logic [REG_IDX_W-1:0]        reg_idx_q, reg_idx_d;
    logic [31:0]                 mem_cnt_q, mem_cnt_d;
    logic [NUM_REGS*DATA_W-1:0]  snapshot_q, snapshot_d;

    logic [REG_IDX_W-1:0]        next_idx;
    logic [31:0]                 mem_next;

    logic                        stage_load;
    logic [DATA_W-1:0]           stage_data;
    logic [ADDR_W-1:0]           stage_index;
    logic                        stage_kind;
    logic                        stage_last;
    logic                        stage_fire;

    dump_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dump_stage (
        .clk      (clk),
        .reset    (reset),
        .load     (stage_load),
        .in_data  (stage_data),
        .in_index (stage_index),
        .in_kind  (stage_kind),
        .in_last  (stage_last),
        .ready    (dump_ready),
        .valid    (dump_valid),
        .data     (dump_data),
        .index    (dump_index),
        .kind     (dump_is_mem),
        .last     (dump_last),
        .fire     (stage_fire)
    );

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign running     = running_q;
    assign done        = done_q;
    assign timed_out   = timed_out_q;
    assign cycle_count = cycle_count_q;

    // Sequencing: run gating, stop detection, snapshot and beat generation.
    always_comb begin
        state_d       = state_q;
        cycle_count_d = cycle_count_q;
        timed_out_d   = timed_out_q;
        mem_addr_d    = mem_addr_q;
        reg_idx_d     = reg_idx_q;
        mem_cnt_d     = mem_cnt_q;
        snapshot_d    = snapshot_q;
        next_idx      = reg_idx_q + 1'b1;
        mem_next      = mem_cnt_q + 32'd1;
        stage_load    = 1'b0;
        stage_data    = '0;
        stage_index   = '0;
        stage_kind    = KIND_REG;
        stage_last    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d       = ST_RUN;
                    cycle_count_d = '0;
                    timed_out_d   = 1'b0;
                end
            end
            ST_RUN: begin
                // A halt takes priority over a watchdog expiry in the same cycle.
                if (halted) begin
                    state_d = ST_SNAP;
                end else begin
                    cycle_count_d = sat_inc(cycle_count_q);
                    if ((TIMEOUT_L != 32'd0) && (cycle_count_d == TIMEOUT_L)) begin
                        state_d     = ST_SNAP;
                        timed_out_d = 1'b1;
                    end
                end
            end
            ST_SNAP: begin
                // Register 0 goes straight from the live file so the first
                // beat is valid on DUMP_REG entry; the rest come from the snapshot.
                snapshot_d  = regs_flat;
                reg_idx_d   = '0;
                mem_cnt_d   = '0;
                state_d     = ST_DUMP_REG;
                stage_load  = 1'b1;
                stage_data  = regs_flat[0 +: DATA_W];
                stage_last  = (LEN_L == 32'd0) && (NUM_REGS == 1);
            end
            ST_DUMP_REG: begin
                if (stage_fire) begin
                    if (reg_idx_q == LAST_REG) begin
                        if (LEN_L != 32'd0) begin
                            state_d    = ST_MEM_RD;
                            mem_addr_d = BASE_L;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        reg_idx_d   = next_idx;
                        stage_load  = 1'b1;
                        stage_data  = snapshot_q[next_idx*DATA_W +: DATA_W];
                        stage_index = ADDR_W'(next_idx);
                        stage_last  = (LEN_L == 32'd0) && (next_idx == LAST_REG);
                    end
                end
            end
            ST_MEM_RD: begin
                state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                stage_load  = 1'b1;
                stage_data  = mem_data;
                stage_index = mem_addr_q;
                stage_kind  = KIND_MEM;
                stage_last  = (mem_next == LEN_L);
                state_d     = ST_DUMP_MEM;
            end
            ST_DUMP_MEM: begin
                if (stage_fire) begin
                    if (mem_next < LEN_L) begin
                        mem_cnt_d  = mem_next;
                        mem_addr_d = BASE_L + ADDR_W'(mem_next);
                        state_d    = ST_MEM_RD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
        mem_rd_d  = (state_d == ST_MEM_RD);
    end

    // Control state and registered outputs, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cycle_count_q <= '0;
            timed_out_q   <= 1'b0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
            reg_idx_q     <= '0;
            mem_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            cycle_count_q <= cycle_count_d;
            timed_out_q   <= timed_out_d;
            running_q     <= running_d;
            done_q        <= done_d;
            mem_rd_q      <= mem_rd_d;
            mem_addr_q    <= mem_addr_d;
            reg_idx_q     <= reg_idx_d;
            mem_cnt_q     <= mem_cnt_d;
        end
    end

    // Register snapshot storage.
    always_ff @(posedge clk) begin
        // NOTE: snapshot is plain storage, always written in SNAP before it is read, so it carries no reset.
        snapshot_q <= snapshot_d;
    end

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: four parameterisations driven with
// directed and randomized runs, checked against a beat-list model.
module tb_run_monitor;

    localparam int NI = 4;
    localparam int NR = 8;

    function automatic int unsigned to_p(input int k);
        case (k)
            1: return 4;
            2: return 0;
            default: return 140;
        endcase
    endfunction

    function automatic int unsigned base_p(input int k);
        case (k)
            1: return 32'h10;
            2: return 32'hFE;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned len_p(input int k);
        case (k)
            1: return 2;
            2: return 4;
            3: return 0;
            default: return 1;
        endcase
    endfunction

    logic             clk = 1'b0;
    logic             reset       [NI];
    logic             start       [NI];
    logic             halted      [NI];
    logic [NR*8-1:0]  regs_flat   [NI];
    logic             mem_rd      [NI];
    logic [7:0]       mem_addr    [NI];
    logic [7:0]       mem_data    [NI];
    logic             dump_valid  [NI];
    logic             dump_ready  [NI];
    logic [7:0]       dump_data   [NI];
    logic             dump_is_mem [NI];
    logic [7:0]       dump_index  [NI];
    logic             dump_last   [NI];
    logic             running     [NI];
    logic             done        [NI];
    logic             timed_out   [NI];
    logic [31:0]      cycle_count [NI];

    logic [7:0]       ram [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gen_dut
        run_monitor #(
            .DATA_W         (8),
            .ADDR_W         (8),
            .NUM_REGS       (NR),
            .TIMEOUT_CYCLES (to_p(g)),
            .DUMP_BASE      (base_p(g)),
            .DUMP_LEN       (len_p(g))
        ) dut (
            .clk         (clk),
            .reset       (reset[g]),
            .start       (start[g]),
            .halted      (halted[g]),
            .regs_flat   (regs_flat[g]),
            .mem_rd      (mem_rd[g]),
            .mem_addr    (mem_addr[g]),
            .mem_data    (mem_data[g]),
            .dump_valid  (dump_valid[g]),
            .dump_ready  (dump_ready[g]),
            .dump_data   (dump_data[g]),
            .dump_is_mem (dump_is_mem[g]),
            .dump_index  (dump_index[g]),
            .dump_last   (dump_last[g]),
            .running     (running[g]),
            .done        (done[g]),
            .timed_out   (timed_out[g]),
            .cycle_count (cycle_count[g])
        );
    end

    // RAM read port seen by every instance: data one cycle after the strobe.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++)
            if (mem_rd[k]) mem_data[k] <= ram[mem_addr[k]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] beat(input logic m, input logic l,
                                         input logic [7:0] i, input logic [7:0] d);
        return {m, l, i, d};
    endfunction

    function automatic logic [17:0] cur_beat(input int k);
        return {dump_is_mem[k], dump_last[k], dump_index[k], dump_data[k]};
    endfunction

    // One full run on instance k: h = RUN cycles with halted low before it
    // rises, mode = ready pattern (0 always, 1 toggling, 2 random).
    task automatic run_case(input string name, input int k, input int h,
                            input int mode, input bit directed);
        logic [17:0] got_q[$];
        logic [17:0] exp_q[$];
        logic [7:0]  addr_q[$];
        logic [7:0]  exp_addr_q[$];
        logic [7:0]  rv [NR];
        logic [7:0]  a;
        logic [17:0] prev_beat;
        bit          prev_stall;
        bit          fin;
        bit          saw_run;
        int          n, cyc, run_cycles, first_low, first_valid;
        int          exp_count, exp_run, nb;
        bit          exp_to;
        int unsigned t, len, base;

        t    = to_p(k);
        len  = len_p(k);
        base = base_p(k);

        for (int i = 0; i < NR; i++) begin
            rv[i] = directed ? 8'(i + 1) : 8'($urandom);
            regs_flat[k][i*8 +: 8] = rv[i];
        end

        // Reference: stop reason, count, and the expected beat stream.
        if (t != 0 && h >= int'(t)) begin
            exp_count = int'(t);
            exp_to    = 1'b1;
            exp_run   = int'(t);
        end else begin
            exp_count = h;
            exp_to    = 1'b0;
            exp_run   = h + 1;
        end
        for (int i = 0; i < NR; i++)
            exp_q.push_back(beat(1'b0, (len == 0) && (i == NR - 1), 8'(i), rv[i]));
        for (int j = 0; j < int'(len); j++) begin
            a = 8'(base + 32'(j));
            exp_addr_q.push_back(a);
            exp_q.push_back(beat(1'b1, j == int'(len) - 1, a, ram[a]));
        end

        @(posedge clk); #1;
        halted[k] = 1'b0;
        start[k]  = 1'b1;
        @(posedge clk); #1;
        start[k]  = 1'b0;
        if (h == 0) halted[k] = 1'b1;

        n = 0; cyc = 0; run_cycles = 0; first_low = -1; first_valid = -1;
        prev_stall = 1'b0; prev_beat = '0; fin = 1'b0; saw_run = 1'b0;
        dump_ready[k] = 1'b0;
        while (!fin && n < 3000) begin
            @(negedge clk);
            if (start[k]) start[k] = 1'b0;
            case (mode)
                0: dump_ready[k] = 1'b1;
                1: dump_ready[k] = (n % 2) == 0;
                default: dump_ready[k] = 1'($urandom);
            endcase
            if (running[k]) begin
                run_cycles++;
                saw_run = 1'b1;
            end else if (saw_run && first_low < 0) begin
                first_low = n;
            end
            if (prev_stall)
                check({name, " stall_hold"}, 64'({dump_valid[k], cur_beat(k)}),
                      64'({1'b1, prev_beat}));
            if (dump_valid[k] && first_valid < 0) begin
                first_valid = n;
                // Live registers change and a stray start arrives mid-dump;
                // neither may disturb the stream.
                regs_flat[k] = ~regs_flat[k];
                start[k] = 1'b1;
            end
            if (dump_valid[k] && dump_ready[k]) got_q.push_back(cur_beat(k));
            if (mem_rd[k]) addr_q.push_back(mem_addr[k]);
            prev_stall = dump_valid[k] && !dump_ready[k];
            prev_beat  = cur_beat(k);
            if (done[k]) fin = 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (cyc == h) halted[k] = 1'b1;
            n++;
        end
        start[k]      = 1'b0;
        halted[k]     = 1'b0;
        dump_ready[k] = 1'b0;

        check({name, " reached_done"}, 64'(fin), 64'(1));
        check({name, " beat_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        nb = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nb; i++)
            check($sformatf("%s beat%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
        check({name, " rd_count"}, 64'(addr_q.size()), 64'(exp_addr_q.size()));
        nb = (addr_q.size() < exp_addr_q.size()) ? addr_q.size() : exp_addr_q.size();
        for (int i = 0; i < nb; i++)
            check($sformatf("%s rd_addr%0d", name, i), 64'(addr_q[i]), 64'(exp_addr_q[i]));
        check({name, " cycle_count"}, 64'(cycle_count[k]), 64'(exp_count));
        check({name, " timed_out"}, 64'(timed_out[k]), 64'(exp_to));
        check({name, " run_cycles"}, 64'(run_cycles), 64'(exp_run));
        check({name, " first_beat_latency"}, 64'(first_valid - first_low), 64'(1));
        check({name, " done_idle"}, 64'({done[k], running[k], dump_valid[k], mem_rd[k]}),
              64'(4'b1000));
    endtask

    // Reset asserted while register beat 2 is presented with ready high.
    task automatic reset_mid(input int k, input int h);
        int  n;
        bit  hit;
        for (int i = 0; i < NR; i++) regs_flat[k][i*8 +: 8] = 8'($urandom);
        @(posedge clk); #1;
        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        if (h == 0) halted[k] = 1'b1;
        n = 0; hit = 1'b0;
        while (!hit && n < 500) begin
            @(negedge clk);
            dump_ready[k] = 1'b1;
            if (dump_valid[k] && !dump_is_mem[k] && dump_index[k] == 8'd2) begin
                reset[k] = 1'b1;
                hit = 1'b1;
            end
            @(posedge clk); #1;
            n++;
            if (n == h) halted[k] = 1'b1;
        end
        reset[k]      = 1'b0;
        halted[k]     = 1'b0;
        dump_ready[k] = 1'b0;
        check("rst_mid reached_beat2", 64'(hit), 64'(1));
        @(negedge clk);
        check("rst_mid outputs", 64'({dump_valid[k], done[k], running[k], mem_rd[k],
                                      timed_out[k], cycle_count[k]}), 64'(0));
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            reset[k]      = 1'b1;
            start[k]      = 1'b0;
            halted[k]     = 1'b0;
            dump_ready[k] = 1'b0;
            regs_flat[k]  = '0;
        end
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        ram[0] = 8'h2A;

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) reset[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++)
            check($sformatf("reset_vals%0d", k),
                  64'({dump_valid[k], mem_rd[k], running[k], done[k], timed_out[k],
                       dump_last[k], dump_is_mem[k], mem_addr[k], dump_data[k],
                       dump_index[k], cycle_count[k]}), 64'(0));

        run_case("halt_path", 0, 10, 0, 1'b1);
        run_case("watchdog", 1, 100, 0, 1'b0);
        run_case("simultaneous", 1, 3, 0, 1'b0);
        run_case("backpressure", 0, 10, 1, 1'b1);
        run_case("wrap", 2, 6, 0, 1'b0);
        run_case("no_mem", 3, 0, 2, 1'b0);
        run_case("timeout_140", 0, 150, 2, 1'b0);

        reset_mid(1, 100);
        run_case("after_reset", 1, 2, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            int k;
            int h;
            k = int'($urandom_range(0, NI - 1));
            h = (k == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 25));
            run_case($sformatf("rand%0d", r), k, h, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
